// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the IF/MEM memory bus arbiter: FSM state codes,
// bus widths and the watchdog counter sizing helper.
package mem_bus_arbiter_pkg;

  localparam int REG_BUS_W   = 32;
  localparam int INST_ADDR_W = 32;

  // Arbiter FSM state codes (3-bit, legacy-compatible encoding)
  localparam logic [2:0] ARB_IDLE   = 3'd0;
  localparam logic [2:0] ARB_D_ACC  = 3'd1;
  localparam logic [2:0] ARB_D_DONE = 3'd2;
  localparam logic [2:0] ARB_I_ACC  = 3'd3;
  localparam logic [2:0] ARB_I_DONE = 3'd4;

  // Instruction fetches always read a full word
  localparam logic [3:0] ARB_SEL_WORD = 4'b1111;

  // Watchdog counter is at least 8 bits and wide enough to hold max_wait
  function automatic int wd_cnt_width(input int max_wait);
    int w;
    w = $clog2(max_wait + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog for the arbiter: counts waiting cycles while enabled and
// flags expiry on the cycle the count reaches MAX_WAIT (0 disables it).
module mem_bus_arbiter_watchdog #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry fires during the MAX_WAIT-th enabled cycle since the last clear
  assign expire_o = (MAX_WAIT != 0) && en_i && (cnt_q == CNT_W'(MAX_WAIT - 1));

  // Next count: clear wins, otherwise count enabled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one req/ack memory bus between instruction fetch and data access.
// Data access wins over fetch; each access is one bus transaction followed
// by a single DONE cycle in which the matching stall request drops.
//
// Bus handshake: bus_req_o rises with stable we/sel/addr/wdata and stays
// high (fields unchanged) until a cycle where bus_ack_i=1 is sampled; that
// edge completes the transaction, captures bus_rdata_i and drops bus_req_o.
// bus_ack_i is ignored while bus_req_o=0. At most one transaction is open.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   if_ce_i,
  input  logic [INST_ADDR_W-1:0] if_addr_i,
  output logic [REG_BUS_W-1:0]   if_data_o,
  output logic                   if_stallreq_o,
  input  logic                   mem_ce_i,
  input  logic                   mem_we_i,
  input  logic [3:0]             mem_sel_i,
  input  logic [REG_BUS_W-1:0]   mem_addr_i,
  input  logic [REG_BUS_W-1:0]   mem_wdata_i,
  output logic [REG_BUS_W-1:0]   mem_rdata_o,
  output logic                   mem_stallreq_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [3:0]             bus_sel_o,
  output logic [REG_BUS_W-1:0]   bus_addr_o,
  output logic [REG_BUS_W-1:0]   bus_wdata_o,
  input  logic [REG_BUS_W-1:0]   bus_rdata_i,
  input  logic                   bus_ack_i,
  output logic                   bus_timeout_o,
  output logic [2:0]             dbg_state_o
);

  localparam int WD_W = wd_cnt_width(MAX_WAIT);

  logic [2:0]           state_q, state_d;
  logic                 discard_q, discard_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [3:0]           bus_sel_q, bus_sel_d;
  logic [REG_BUS_W-1:0] bus_addr_q, bus_addr_d;
  logic [REG_BUS_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [REG_BUS_W-1:0] if_data_q, if_data_d;
  logic [REG_BUS_W-1:0] mem_rdata_q, mem_rdata_d;
  logic                 timeout_q, timeout_d;
  logic                 in_acc;
  logic                 wd_expire;

  assign in_acc = (state_q == ARB_D_ACC) || (state_q == ARB_I_ACC);

  // Counter is held clear outside the access states, so it restarts on entry
  mem_bus_arbiter_watchdog #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_acc),
    .en_i     (in_acc && !bus_ack_i),
    .expire_o (wd_expire)
  );

  // Next-state and registered-output logic of the arbiter FSM
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    timeout_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (mem_ce_i) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          state_d     = ARB_D_ACC;
        end else if (if_ce_i && !flush) begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_sel_d  = ARB_SEL_WORD;
          bus_addr_d = if_addr_i;
          state_d    = ARB_I_ACC;
        end
      end
      ARB_D_ACC: begin
        // A flush here is harmless: ctrl only flushes once MEM dropped ce
        if (bus_ack_i || wd_expire) begin
          bus_req_d = 1'b0;
          timeout_d = !bus_ack_i;
          if (!bus_we_q) begin
            mem_rdata_d = bus_ack_i ? bus_rdata_i : '0;
          end
          state_d = ARB_D_DONE;
        end
      end
      ARB_I_ACC: begin
        // The open transaction always runs to completion; a flush only
        // marks its result as unwanted
        if (flush) begin
          discard_d = 1'b1;
        end
        if (bus_ack_i || wd_expire) begin
          bus_req_d = 1'b0;
          timeout_d = !bus_ack_i;
          discard_d = 1'b0;
          if (discard_q || flush) begin
            state_d = ARB_IDLE;
          end else begin
            if_data_d = bus_ack_i ? bus_rdata_i : '0;
            state_d   = ARB_I_DONE;
          end
        end
      end
      ARB_D_DONE, ARB_I_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      discard_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  // Stalls are combinational so they rise in the same cycle as the request;
  // a discarded fetch keeps IF stalled until its bus transaction finishes
  assign mem_stallreq_o = !rst && mem_ce_i && (state_q != ARB_D_DONE);
  assign if_stallreq_o  = !rst && ((if_ce_i && (state_q != ARB_I_DONE)) ||
                                   ((state_q == ARB_I_ACC) && discard_q));

  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = bus_we_q;
  assign bus_sel_o     = bus_sel_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign if_data_o     = if_data_q;
  assign mem_rdata_o   = mem_rdata_q;
  assign bus_timeout_o = timeout_q;
  assign dbg_state_o   = state_q;

endmodule
